// File: rtl/keypad_scan_controller_if.sv
// Keypad scan controller bus: keypad row/column lines plus the decoded key
// outputs. The master side is the scan controller; the slave side is the
// keypad/consumer side that drives the rows and observes the key outputs.
interface keypad_scan_controller_if;
   logic [3:0] row;
   logic [3:0] shift_col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  row,
      output shift_col,
      output key_code,
      output key_valid,
      output key_held
   );

   modport slave (
      output row,
      input  shift_col,
      input  key_code,
      input  key_valid,
      input  key_held
   );
endinterface

// File: rtl/keypad_scan_controller.sv
// 4x4 hex keypad scanner: strobes one column low at a time, samples the
// synchronized rows, debounces press and release of a single key and reports
// its code with a one-cycle valid pulse. Simultaneous rows low in one column
// are treated as ghosting and ignored.
// Optional feature macro: KEYPAD_REPEAT_EN adds auto-repeat pulses while a
// key stays held.
module keypad_scan_controller #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int REPEAT_CYCLES   = 200000
) (
   input logic                      clk,
   input logic                      reset,
   keypad_scan_controller_if.master bus
);

   localparam int DWELL_W = $clog2(SCAN_DIV);
   localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD,
      RELEASE
   } state_t;

   state_t             state, state_n;
   logic [3:0]         row_meta, row_s;
   logic [DWELL_W-1:0] dwell, dwell_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [3:0]         cap_row, cap_row_n;
   logic [3:0]         shift_col_r, shift_col_n;
   logic [3:0]         key_code_r, key_code_n;
   logic               key_valid_r, key_valid_n;
   logic               key_held_r, key_held_n;

`ifdef KEYPAD_REPEAT_EN
   localparam int RPT_W = $clog2(DEBOUNCE_CYCLES + REPEAT_CYCLES);
   localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(DEBOUNCE_CYCLES + REPEAT_CYCLES - 1);
   localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(DEBOUNCE_CYCLES);
   logic [RPT_W-1:0] rpt, rpt_n;
`endif

   // True when exactly one row line is pulled low
   function automatic logic single_low(input logic [3:0] v);
      logic [3:0] low;
      low = ~v;
      return (low != 4'b0000) && ((low & (low - 4'd1)) == 4'b0000);
   endfunction

   // Bit position of the low line in a one-cold pattern
   function automatic logic [1:0] low_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // Two-flop synchronizer for the asynchronous row lines (idle high)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_meta <= 4'b1111;
         row_s    <= 4'b1111;
      end else begin
         row_meta <= bus.row;
         row_s    <= row_meta;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= SCAN;
         dwell       <= '0;
         cnt         <= '0;
         cap_row     <= 4'b1111;
         shift_col_r <= 4'b1110;
         key_code_r  <= 4'h0;
         key_valid_r <= 1'b0;
         key_held_r  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rpt         <= '0;
`endif
      end else begin
         state       <= state_n;
         dwell       <= dwell_n;
         cnt         <= cnt_n;
         cap_row     <= cap_row_n;
         shift_col_r <= shift_col_n;
         key_code_r  <= key_code_n;
         key_valid_r <= key_valid_n;
         key_held_r  <= key_held_n;
`ifdef KEYPAD_REPEAT_EN
         rpt         <= rpt_n;
`endif
      end
   end

   // Scan/debounce/held/release sequencing; every state change clears the counters
   always_comb begin
      state_n     = state;
      dwell_n     = dwell;
      cnt_n       = cnt;
      cap_row_n   = cap_row;
      shift_col_n = shift_col_r;
      key_code_n  = key_code_r;
      key_valid_n = 1'b0;
      key_held_n  = key_held_r;
`ifdef KEYPAD_REPEAT_EN
      rpt_n       = rpt;
`endif
      case (state)
         SCAN: begin
            if (dwell == DWELL_LAST) begin
               dwell_n = '0;
               if (single_low(row_s)) begin
                  cap_row_n = row_s;
                  cnt_n     = '0;
                  state_n   = DEBOUNCE;
               end else begin
                  shift_col_n = {shift_col_r[2:0], shift_col_r[3]};
               end
            end else begin
               dwell_n = dwell + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (row_s != cap_row) begin
               state_n = SCAN;
               dwell_n = '0;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               key_code_n  = {low_index(shift_col_r), low_index(cap_row)};
               key_valid_n = 1'b1;
               key_held_n  = 1'b1;
               cnt_n       = '0;
               state_n     = HELD;
`ifdef KEYPAD_REPEAT_EN
               rpt_n       = '0;
`endif
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         HELD: begin
            if (row_s == 4'b1111) begin
               cnt_n   = '0;
               state_n = RELEASE;
`ifdef KEYPAD_REPEAT_EN
               rpt_n   = '0;
            end else if (rpt == RPT_LAST) begin
               key_valid_n = 1'b1;
               rpt_n       = RPT_RELOAD;
            end else begin
               rpt_n = rpt + 1'b1;
`endif
            end
         end
         RELEASE: begin
            if (row_s != 4'b1111) begin
               cnt_n   = '0;
               state_n = HELD;
            end else if (cnt == CNT_LAST) begin
               cnt_n       = '0;
               dwell_n     = '0;
               key_held_n  = 1'b0;
               shift_col_n = {shift_col_r[2:0], shift_col_r[3]};
               state_n     = SCAN;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = SCAN;
         end
      endcase
   end

   assign bus.shift_col = shift_col_r;
   assign bus.key_code  = key_code_r;
   assign bus.key_valid = key_valid_r;
   assign bus.key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Testbench for keypad_scan_controller: a physical 4x4 keypad model turns a
// 16-bit pressed-key mask into row levels; press transactions come from a
// vector table, hand-written timing sequences and a random loop whose
// expectations are derived from key index = {column, row}.
module tb_keypad_scan_controller;

   localparam int SCAN_DIV        = 4;
   localparam int DEBOUNCE_CYCLES = 8;
   localparam int REPEAT_CYCLES   = 16;

   typedef struct {
      logic [15:0] mask;
      int          bounce_clks;
      int          hold_clks;
      int          exp_pulses;
      logic [3:0]  exp_code;
   } press_vec_t;

   logic        clk;
   logic        reset;
   logic [15:0] pressed;
   int          checks;
   int          failures;
   int          pulse_cnt;
   logic [3:0]  last_code;
   logic [3:0]  model_code;
   press_vec_t  vecs[6];

   keypad_scan_controller_if kif ();

   keypad_scan_controller #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (kif.master)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Keypad matrix: a pressed key pulls its row low while its column is strobed
   always_comb begin
      kif.row = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (pressed[c*4+r] && !kif.shift_col[c]) kif.row[r] = 1'b0;
         end
      end
   end

   // Safety net so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [3:0] col_strobe(input int idx);
      logic [3:0] one;
      one = 4'b0001 << (idx % 4);
      return ~one;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (kif.key_valid === 1'b1) begin
         pulse_cnt++;
         last_code = kif.key_code;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic applyStimulus(input press_vec_t v);
      int col;
      col = 0;
      for (int i = 0; i < 16; i++) begin
         if (v.mask[i]) col = i / 4;
      end
      pulse_cnt = 0;
      for (int i = 0; i < v.bounce_clks; i++) begin
         pressed = (((i / 3) % 2) == 0) ? v.mask : 16'h0000;
         tick();
      end
      pressed = v.mask;
      repeat (v.hold_clks) tick();
      if (v.exp_pulses > 0) begin
         checkOutput("held_while_pressed", kif.key_held, 1);
         checkOutput("col_frozen", kif.shift_col, col_strobe(col));
      end
      pressed = 16'h0000;
      for (int i = 0; i < 40 && kif.key_held; i++) tick();
      checkOutput("release_done", kif.key_held, 0);
      if (v.exp_pulses > 0) checkOutput("resume_next_col", kif.shift_col, col_strobe(col + 1));
      checkOutput("pulse_count", pulse_cnt, v.exp_pulses);
      checkOutput("key_code", kif.key_code, v.exp_code);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      pulse_cnt = 0;
      last_code = 4'h0;
      pressed   = 16'h0000;
      reset     = 1'b1;

      vecs[0] = '{mask: 16'h8000, bounce_clks: 0,  hold_clks: 45, exp_pulses: 1, exp_code: 4'hF};
      vecs[1] = '{mask: 16'h0002, bounce_clks: 60, hold_clks: 45, exp_pulses: 1, exp_code: 4'h1};
      vecs[2] = '{mask: 16'hC000, bounce_clks: 0,  hold_clks: 45, exp_pulses: 0, exp_code: 4'h1};
      vecs[3] = '{mask: 16'h4000, bounce_clks: 0,  hold_clks: 45, exp_pulses: 1, exp_code: 4'hE};
      vecs[4] = '{mask: 16'h0001, bounce_clks: 0,  hold_clks: 45, exp_pulses: 1, exp_code: 4'h0};
      vecs[5] = '{mask: 16'h0400, bounce_clks: 20, hold_clks: 45, exp_pulses: 1, exp_code: 4'hA};

      // Reset values
      do_reset();
      checkOutput("rst_shift_col", kif.shift_col, 4'b1110);
      checkOutput("rst_key_code", kif.key_code, 4'h0);
      checkOutput("rst_key_valid", kif.key_valid, 0);
      checkOutput("rst_key_held", kif.key_held, 0);

      // Idle scan: one column per SCAN_DIV clocks, no output
      for (int k = 1; k <= 16; k++) begin
         tick();
         checkOutput("idle_shift_col", kif.shift_col, col_strobe(k / SCAN_DIV));
         checkOutput("idle_key_valid", kif.key_valid, 0);
         checkOutput("idle_key_code", kif.key_code, 4'h0);
      end

      // Press F from the start of column 0: accept lands on the 24th edge
      pressed = 16'h8000;
      for (int j = 1; j <= 40; j++) begin
         tick();
         checkOutput("lat_key_valid", kif.key_valid, (j == 24) ? 1 : 0);
         checkOutput("lat_key_held", kif.key_held, (j >= 24) ? 1 : 0);
         checkOutput("lat_shift_col", kif.shift_col, (j < 12) ? col_strobe(j / SCAN_DIV) : 4'b0111);
      end
      checkOutput("lat_key_code", kif.key_code, 4'hF);

      // Release: key_held drops and scanning moves on after the release debounce
      pressed = 16'h0000;
      for (int e = 1; e <= 12; e++) begin
         tick();
         checkOutput("rel_key_held", kif.key_held, (e < 11) ? 1 : 0);
         checkOutput("rel_shift_col", kif.shift_col, (e < 11) ? 4'b0111 : 4'b1110);
         checkOutput("rel_key_valid", kif.key_valid, 0);
      end

      // Table of press transactions
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      // Release glitch: a short re-press during release gives no new pulse
      pulse_cnt = 0;
      pressed   = 16'h4000;
      for (int i = 0; i < 40 && pulse_cnt == 0; i++) tick();
      checkOutput("glitch_first_pulse", pulse_cnt, 1);
      checkOutput("glitch_code", last_code, 4'hE);
      repeat (3) tick();
      pressed = 16'h0000;
      for (int e = 1; e <= 17; e++) begin
         tick();
         if (e == 4) pressed = 16'h4000;
         if (e == 6) pressed = 16'h0000;
         checkOutput("glitch_key_held", kif.key_held, (e < 17) ? 1 : 0);
      end
      checkOutput("glitch_no_repulse", pulse_cnt, 1);

      // Reset during DEBOUNCE of key 5 (column 1) acts without a clock edge
      do_reset();
      pressed = 16'h0020;
      repeat (10) tick();
      checkOutput("deb_col_frozen", kif.shift_col, 4'b1101);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_rst_shift_col", kif.shift_col, 4'b1110);
      checkOutput("async_rst_key_valid", kif.key_valid, 0);
      checkOutput("async_rst_key_held", kif.key_held, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Key still held after reset is picked up as a fresh press
      pulse_cnt = 0;
      for (int i = 0; i < 40 && pulse_cnt == 0; i++) tick();
      checkOutput("redetect_pulse", pulse_cnt, 1);
      checkOutput("redetect_code", last_code, 4'h5);
      checkOutput("redetect_held", kif.key_held, 1);
      #2 reset = 1'b1;
      #1;
      checkOutput("held_rst_key_held", kif.key_held, 0);
      checkOutput("held_rst_key_code", kif.key_code, 4'h0);
      checkOutput("held_rst_shift_col", kif.shift_col, 4'b1110);
      pressed = 16'h0000;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Random presses and ghost pairs against the transaction-level model
      model_code = 4'h0;
      for (int n = 0; n < 12; n++) begin
         press_vec_t v;
         int k;
         int r2;
         logic ghost;
         k     = int'($urandom_range(0, 15));
         ghost = ($urandom_range(0, 3) == 0);
         v.mask = 16'h0000;
         v.mask[k] = 1'b1;
         if (ghost) begin
            r2 = ((k % 4) + int'($urandom_range(1, 3))) % 4;
            v.mask[(k / 4) * 4 + r2] = 1'b1;
         end
         v.bounce_clks = int'($urandom_range(0, 24));
         v.hold_clks   = 45 + int'($urandom_range(0, 15));
         if (ghost) begin
            v.exp_pulses = 0;
         end else begin
            v.exp_pulses = 1;
            model_code   = 4'(k);
         end
         v.exp_code = model_code;
         applyStimulus(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
